axis_cplx_weight: RTL and testbench
===================================

Name: axis_cplx_weight

Overview:
- Per-channel complex beamforming weight stage, instantiated once per channel (00, 01, 20, 21).
- Sits directly upstream of the four-channel summing adder and feeds its s*_axis_real/imag inputs.
- Multiplies each 16-bit complex sample (real and imag on separate AXI streams, 8 samples per beat) by a runtime-loadable 8-bit complex weight.
- Rounds, saturates back to 16 bits and outputs paired real/imag streams with tkeep and tlast.

Parameters:
SDATA_WIDTH, 128, input/output tdata width per stream
SSAMPLE_WIDTH, 16, signed sample width (in and out)
WEIGHT_WIDTH, 8, signed weight width, Q1.(WEIGHT_WIDTH-1)
SAMPLES, SDATA_WIDTH/SSAMPLE_WIDTH, samples per beat

Ports:
clock  in  1  sole clock
resetn  in  1  synchronous active-low reset
s_axis_real_tvalid/tready/tdata/tlast  in/out/in/in  1/1/128/1  real input stream
s_axis_imag_tvalid/tready/tdata/tlast  in/out/in/in  1/1/128/1  imag input stream
weight_re  in  8  signed real weight
weight_im  in  8  signed imag weight
weight_valid  in  1  one-cycle strobe: capture weight_re/im into shadow
m_axis_real_s2mm_tdata/tkeep/tlast/tvalid/tready  out/out/out/out/in  128/16/1/1/1  real output
m_axis_imag_s2mm_tdata/tkeep/tlast/tvalid/tready  out/out/out/out/in  128/16/1/1/1  imag output
sat_count  out  16  saturating count of clipped output samples (real and imag each count)

Behaviour:
- Reset (resetn=0 at posedge):
  - all m tvalid/tlast=0, tdata=0, tkeep=0.
  - Both s tready=0 in the reset cycle.
  - Active and shadow weights = 127 + j0; pending=0; sat_count=0; state=IDLE; pipeline valid bits cleared.
- Join: a beat is accepted only when s_real_tvalid && s_imag_tvalid && adv.
  - adv = !stage3_valid || (m_real_tready && m_imag_tready).
  - Both s tready = adv (identical, combinational). tlast taken from real stream.
- Pipeline, 3 stages, latency 3 cycles from accept to m tvalid when not stalled; all stages advance only on adv.
  - S1: register samples a=re, b=im and the active weights c, d.
  - S2: four signed 24-bit products ac, bd, ad, bc.
  - S3: re = ac-bd, im = ad+bc (25-bit). Add 2^(WEIGHT_WIDTH-2)=64, arithmetic shift right by 7, saturate to [-32768, 32767].
- Output:
  - m_real and m_imag tvalid always asserted/deasserted together.
  - tkeep = all ones (16'hFFFF) when tvalid, else 0.
  - Data and tlast held stable while tvalid && !(both tready).
- Weight update FSM (IDLE, IN_PKT):
  - weight_valid: shadow <= inputs, pending <= 1. A later strobe before apply overwrites the shadow.
  - Shadow is copied to active only in IDLE (no packet in progress), on the cycle after pending is set. Weights never change mid-packet.
  - IDLE -> IN_PKT on accepting a beat with tlast=0; IN_PKT -> IDLE on accepting a beat with tlast=1. A tlast=1 beat accepted in IDLE stays IDLE.
  - Weight load and beat accept in the same IDLE cycle: that beat uses the old active weights; the new weights apply from the next packet boundary.
- sat_count:
  - Increments by the number of clipped samples in each beat leaving S3 on adv (0..16).
  - Sticks at 16'hFFFF.
- Mismatched valid (only one of real/imag valid): no accept, no state change.
- Reset mid-operation flushes the pipeline. In-flight beats are discarded and no partial output is emitted.

Test Plan:
- Post-reset, weights 127+j0, all samples re=1000, im=0, tlast=1, tready=1 -> 3 cycles later all real samples 992, imag 0, tkeep=FFFF, tlast=1, sat_count=0.
- Load 64+j0; input re=1001, im=1000 -> re=501 (tie rounds up), im=500.
- Load 0+j64; input re=1000, im=200 -> re=-100 (-99.5 floors after +64), im=500.
- Load -128+j0; input re=-32768 in all 8 samples, im=0 -> re=32767 saturated, im=0, sat_count=8.
- Packet of 4 beats, weight_valid pulsed at beat 2 -> beats 1-4 use old weights; first beat of next packet uses new weights.
- Stall checks:
  - m_real_tready=1, m_imag_tready=0 for 5 cycles with 3 beats in flight -> outputs stable, s tready=0, no beat lost or duplicated.
  - s_real_tvalid=1, s_imag_tvalid=0 -> no accept.

Source files
------------

// File: rtl/axis_cplx_weight_if.sv
// AXI-Stream bundle shared by the weight stage's sample inputs and paired outputs.
// tkeep is carried on the inputs only for symmetry; the stage does not use it.
interface axis_cplx_weight_if #(
  parameter int unsigned DATA_WIDTH = 128
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_cplx_weight.sv
// Per-channel complex weight stage: joins real/imag sample streams, multiplies each sample by a
// runtime-loadable Q1.7 complex weight, rounds and saturates back to 16 bits (3-stage pipeline).
module axis_cplx_weight #(
  parameter int unsigned SDATA_WIDTH   = 128,
  parameter int unsigned SSAMPLE_WIDTH = 16,
  parameter int unsigned WEIGHT_WIDTH  = 8,
  parameter int unsigned SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH
) (
  input  logic                           clock,
  input  logic                           resetn,
  axis_cplx_weight_if.slave              s_axis_real,
  axis_cplx_weight_if.slave              s_axis_imag,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_re,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_im,
  input  logic                           weight_valid,
  axis_cplx_weight_if.master             m_axis_real_s2mm,
  axis_cplx_weight_if.master             m_axis_imag_s2mm,
  output logic [15:0]                    sat_count
);

  localparam int unsigned ProdW = SSAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned SumW  = ProdW + 1;
  localparam int unsigned CntW  = $clog2(2 * SAMPLES + 1);
  localparam logic signed [WEIGHT_WIDTH-1:0] WOne = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
  localparam logic signed [SumW-1:0] RoundC = SumW'(1) << (WEIGHT_WIDTH - 2);
  localparam logic signed [SumW-1:0] SatMax = (SumW'(1) << (SSAMPLE_WIDTH - 1)) - SumW'(1);
  localparam logic signed [SumW-1:0] SatMin = ~SatMax;

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  function automatic logic signed [ProdW-1:0] mul(input logic signed [SSAMPLE_WIDTH-1:0] x,
                                                  input logic signed [WEIGHT_WIDTH-1:0] w);
    logic signed [ProdW-1:0] xe;
    logic signed [ProdW-1:0] we;
    xe = {{WEIGHT_WIDTH{x[SSAMPLE_WIDTH-1]}}, x};
    we = {{SSAMPLE_WIDTH{w[WEIGHT_WIDTH-1]}}, w};
    return xe * we;
  endfunction

  function automatic logic signed [SumW-1:0] sx(input logic signed [ProdW-1:0] p);
    return {p[ProdW-1], p};
  endfunction

  // Returns {clipped, sample}: round half up, drop the Q1.7 fraction, clamp to 16 bits.
  function automatic logic [SSAMPLE_WIDTH:0] rnd_sat(input logic signed [SumW-1:0] x);
    logic signed [SumW-1:0] r;
    r = x + RoundC;
    r = r >>> (WEIGHT_WIDTH - 1);
    if (r > SatMax) return {1'b1, SatMax[SSAMPLE_WIDTH-1:0]};
    if (r < SatMin) return {1'b1, SatMin[SSAMPLE_WIDTH-1:0]};
    return {1'b0, r[SSAMPLE_WIDTH-1:0]};
  endfunction

  state_e                          r_state, w_state_d;
  logic                            w_adv, w_accept, w_apply, w_unused;
  logic signed [WEIGHT_WIDTH-1:0]  r_aw_re, r_aw_im, r_sw_re, r_sw_im;
  logic                            r_pend;
  logic signed [SSAMPLE_WIDTH-1:0] r_a [SAMPLES];
  logic signed [SSAMPLE_WIDTH-1:0] r_b [SAMPLES];
  logic signed [WEIGHT_WIDTH-1:0]  r_c, r_d;
  logic signed [ProdW-1:0]         r_ac [SAMPLES];
  logic signed [ProdW-1:0]         r_bd [SAMPLES];
  logic signed [ProdW-1:0]         r_ad [SAMPLES];
  logic signed [ProdW-1:0]         r_bc [SAMPLES];
  logic                            r_v1, r_v2, r_v3, r_last1, r_last2, r_last3;
  logic [SDATA_WIDTH-1:0]          r_re, r_im, w_re_data, w_im_data;
  logic [SAMPLES-1:0]              w_clip_re, w_clip_im;
  logic [CntW-1:0]                 w_clips;
  logic [16:0]                     w_sat_sum;
  logic [15:0]                     r_sat;

  assign w_unused = ^{s_axis_real.tkeep, s_axis_imag.tkeep, s_axis_imag.tlast};

  // The whole pipeline moves in lockstep; it only stalls when the output register is full
  // and either downstream stream is not ready.
  assign w_adv    = !r_v3 || (m_axis_real_s2mm.tready && m_axis_imag_s2mm.tready);
  assign w_accept = s_axis_real.tvalid && s_axis_imag.tvalid && w_adv && resetn;

  assign s_axis_real.tready = resetn && w_adv;
  assign s_axis_imag.tready = resetn && w_adv;

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept && !s_axis_real.tlast) w_state_d = StInPkt;
      StInPkt: if (w_accept && s_axis_real.tlast)  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // A beat that opens a multi-beat packet blocks the copy so weights stay fixed for the packet.
  always_comb begin
    w_apply = (r_state == StIdle) && r_pend && !(w_accept && !s_axis_real.tlast);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sw_re <= WOne;
      r_sw_im <= '0;
      r_aw_re <= WOne;
      r_aw_im <= '0;
      r_pend  <= 1'b0;
    end else begin
      if (weight_valid) begin
        r_sw_re <= weight_re;
        r_sw_im <= weight_im;
        r_pend  <= 1'b1;
      end else if (w_apply) begin
        r_pend  <= 1'b0;
      end
      if (w_apply) begin
        r_aw_re <= r_sw_re;
        r_aw_im <= r_sw_im;
      end
    end
  end

  always_comb begin
    w_re_data = '0;
    w_im_data = '0;
    w_clip_re = '0;
    w_clip_im = '0;
    w_clips   = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      {w_clip_re[i], w_re_data[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]} =
          rnd_sat(sx(r_ac[i]) - sx(r_bd[i]));
      {w_clip_im[i], w_im_data[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]} =
          rnd_sat(sx(r_ad[i]) + sx(r_bc[i]));
      w_clips = w_clips + CntW'(w_clip_re[i]) + CntW'(w_clip_im[i]);
    end
  end

  assign w_sat_sum = {1'b0, r_sat} + 17'(w_clips);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_last1 <= 1'b0;
      r_last2 <= 1'b0;
      r_last3 <= 1'b0;
      r_c     <= '0;
      r_d     <= '0;
      r_re    <= '0;
      r_im    <= '0;
      r_sat   <= '0;
      for (int i = 0; i < SAMPLES; i++) begin
        r_a[i]  <= '0;
        r_b[i]  <= '0;
        r_ac[i] <= '0;
        r_bd[i] <= '0;
        r_ad[i] <= '0;
        r_bc[i] <= '0;
      end
    end else if (w_adv) begin
      r_v1    <= w_accept;
      r_last1 <= s_axis_real.tlast;
      r_c     <= r_aw_re;
      r_d     <= r_aw_im;
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      r_v3    <= r_v2;
      r_last3 <= r_last2;
      r_re    <= w_re_data;
      r_im    <= w_im_data;
      for (int i = 0; i < SAMPLES; i++) begin
        r_a[i]  <= s_axis_real.tdata[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH];
        r_b[i]  <= s_axis_imag.tdata[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH];
        r_ac[i] <= mul(r_a[i], r_c);
        r_bd[i] <= mul(r_b[i], r_d);
        r_ad[i] <= mul(r_a[i], r_d);
        r_bc[i] <= mul(r_b[i], r_c);
      end
      if (r_v2) r_sat <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end
  end

  assign m_axis_real_s2mm.tvalid = r_v3;
  assign m_axis_imag_s2mm.tvalid = r_v3;
  assign m_axis_real_s2mm.tdata  = r_re;
  assign m_axis_imag_s2mm.tdata  = r_im;
  assign m_axis_real_s2mm.tlast  = r_last3;
  assign m_axis_imag_s2mm.tlast  = r_last3;
  assign m_axis_real_s2mm.tkeep  = r_v3 ? '1 : '0;
  assign m_axis_imag_s2mm.tkeep  = r_v3 ? '1 : '0;
  assign sat_count               = r_sat;

endmodule

// File: tb/tb_axis_cplx_weight.sv
// Directed bench for axis_cplx_weight: table of single-beat weight/sample vectors plus
// hand-written packet, stall, mismatched-valid, reset-flush and counter-saturation sequences.
module tb_axis_cplx_weight;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic signed [7:0] weight_re, weight_im;
  logic              weight_valid;
  logic [15:0]       sat_count;

  always #5 clock = ~clock;

  axis_cplx_weight_if s_re ();
  axis_cplx_weight_if s_im ();
  axis_cplx_weight_if m_re ();
  axis_cplx_weight_if m_im ();

  axis_cplx_weight dut (
    .clock            (clock),
    .resetn           (resetn),
    .s_axis_real      (s_re),
    .s_axis_imag      (s_im),
    .weight_re        (weight_re),
    .weight_im        (weight_im),
    .weight_valid     (weight_valid),
    .m_axis_real_s2mm (m_re),
    .m_axis_imag_s2mm (m_im),
    .sat_count        (sat_count)
  );

  typedef struct {
    logic signed [7:0]  wr;
    logic signed [7:0]  wi;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [15:0] er;
    logic signed [15:0] ei;
    logic [15:0]        esat;
  } vec_t;

  vec_t         vt[7];
  int           passed = 0, total = 0;
  int           pair_err = 0, keep_err = 0;
  logic [127:0] q_re[$], q_im[$];
  logic         q_last[$];

  // Captures every completed output transfer; sampled mid-cycle.
  always @(negedge clock) begin
    if (resetn) begin
      if (m_re.tvalid !== m_im.tvalid) pair_err++;
      if (m_re.tkeep !== (m_re.tvalid ? 16'hFFFF : 16'h0)) keep_err++;
      if (m_im.tkeep !== (m_im.tvalid ? 16'hFFFF : 16'h0)) keep_err++;
      if (m_re.tvalid && m_re.tready && m_im.tvalid && m_im.tready) begin
        q_re.push_back(m_re.tdata);
        q_im.push_back(m_im.tdata);
        q_last.push_back(m_re.tlast);
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic last);
    s_re.tdata  = {8{a}};
    s_im.tdata  = {8{b}};
    s_re.tlast  = last;
    s_im.tlast  = last;
    s_re.tvalid = 1'b1;
    s_im.tvalid = 1'b1;
  endtask

  task automatic wait_acc(input string name);
    bit acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clock);
      acc = s_re.tready && s_im.tready && s_re.tvalid && s_im.tvalid;
      tick();
    end
    s_re.tvalid = 1'b0;
    s_im.tvalid = 1'b0;
    if (!acc) begin
      total++;
      $display("FAIL %s: beat not accepted within 20 cycles", name);
    end
  endtask

  task automatic wait_out(input int n, input string name);
    for (int k = 0; k < 50 && q_re.size() < n; k++) tick();
    if (q_re.size() < n) begin
      total++;
      $display("FAIL %s: got %0d output beats, expected %0d", name, q_re.size(), n);
    end
  endtask

  task automatic load_w(input logic signed [7:0] wr, input logic signed [7:0] wi);
    weight_re    = wr;
    weight_im    = wi;
    weight_valid = 1'b1;
    tick();
    weight_valid = 1'b0;
    tick();
  endtask

  task automatic clear_q();
    q_re.delete();
    q_im.delete();
    q_last.delete();
  endtask

  initial begin
    logic [15:0]  s16;
    logic [127:0] lane_in, lane_exp, held;
    bit           stall_ok, stable_ok;
    int           lat;

    vt[0] = '{8'sd127,  8'sd0,    16'sd1000,   16'sd0,     16'sd992,    16'sd0,   16'd0};
    vt[1] = '{8'sd64,   8'sd0,    16'sd1001,   16'sd1000,  16'sd501,    16'sd500, 16'd0};
    vt[2] = '{8'sd0,    8'sd64,   16'sd1000,   16'sd200,   -16'sd100,   16'sd500, 16'd0};
    vt[3] = '{-8'sd128, 8'sd0,    -16'sd32768, 16'sd0,     16'sd32767,  16'sd0,   16'd8};
    vt[4] = '{-8'sd128, -8'sd128, -16'sd32768, -16'sd32768, 16'sd0,     16'sd32767, 16'd16};
    vt[5] = '{8'sd127,  8'sd127,  -16'sd32768, 16'sd32767, -16'sd32768, -16'sd1,  16'd24};
    vt[6] = '{-8'sd1,   8'sd1,    16'sd100,    -16'sd50,   16'sd0,      16'sd1,   16'd24};

    weight_re = '0; weight_im = '0; weight_valid = 1'b0;
    s_re.tvalid = 1'b0; s_im.tvalid = 1'b0; s_re.tlast = 1'b0; s_im.tlast = 1'b0;
    s_re.tdata = '0; s_im.tdata = '0; s_re.tkeep = '1; s_im.tkeep = '1;
    m_re.tready = 1'b1; m_im.tready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_s_tready", {s_re.tready, s_im.tready}, 2'b00);
    check("rst_m_tvalid", {m_re.tvalid, m_im.tvalid, m_re.tlast, m_im.tlast}, 4'b0);
    check("rst_tkeep", {m_re.tkeep, m_im.tkeep}, 32'h0);
    check("rst_tdata", m_re.tdata | m_im.tdata, 128'h0);
    check("rst_sat", sat_count, 16'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Reset weights 127+j0, latency and output fields
    drive(16'd1000, 16'd0, 1'b1);
    wait_acc("lat_acc");
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      lat++;
      if (m_re.tvalid) break;
      tick();
    end
    check("latency", lat, 3);
    check("lat_re", m_re.tdata, {8{16'd992}});
    check("lat_im", m_im.tdata, 128'h0);
    check("lat_keep", {m_re.tkeep, m_im.tkeep}, 32'hFFFF_FFFF);
    check("lat_last", {m_re.tlast, m_im.tlast, m_im.tvalid}, 3'b111);
    check("lat_sat", sat_count, 16'd0);
    tick();
    tick();
    clear_q();

    // Table of single-beat vectors
    for (int i = 0; i < 7; i++) begin
      load_w(vt[i].wr, vt[i].wi);
      drive(vt[i].a, vt[i].b, 1'b1);
      wait_acc($sformatf("vec%0d_acc", i));
      wait_out(1, $sformatf("vec%0d_out", i));
      check($sformatf("vec%0d_re", i), q_re.pop_front(), {8{vt[i].er}});
      check($sformatf("vec%0d_im", i), q_im.pop_front(), {8{vt[i].ei}});
      check($sformatf("vec%0d_last", i), q_last.pop_front(), 1'b1);
      tick();
      check($sformatf("vec%0d_sat", i), sat_count, vt[i].esat);
    end
    clear_q();

    // 4-beat packet, weight strobe with beat 2; new weight only from the next packet
    load_w(8'sd127, 8'sd0);
    for (int k = 0; k < 4; k++) begin
      drive(16'd1000, 16'd0, k == 3);
      if (k == 1) begin
        weight_re = 8'sd64; weight_im = 8'sd0; weight_valid = 1'b1;
      end
      wait_acc($sformatf("pkt_b%0d", k));
      weight_valid = 1'b0;
    end
    tick();
    tick();
    drive(16'd1000, 16'd0, 1'b1);
    wait_acc("pkt_next");
    wait_out(5, "pkt_out");
    for (int k = 0; k < 5; k++) begin
      s16 = (k < 4) ? 16'd992 : 16'd500;
      check($sformatf("pkt_re%0d", k), q_re.pop_front(), {8{s16}});
      check($sformatf("pkt_last%0d", k), q_last.pop_front(), (k >= 3));
      void'(q_im.pop_front());
    end
    clear_q();

    // Imag ready low with 3 beats in flight; weights are 64+j0
    m_im.tready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      s16 = 16'(128 * k);
      drive(s16, 16'd0, 1'b1);
      wait_acc($sformatf("stall_b%0d", k));
    end
    drive(16'd512, 16'd0, 1'b1);
    stall_ok = 1'b1;
    stable_ok = 1'b1;
    held = {8{16'd64}};
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (s_re.tready || s_im.tready) stall_ok = 1'b0;
      if (!m_re.tvalid || m_re.tdata !== held || m_im.tdata !== 128'h0) stable_ok = 1'b0;
      tick();
    end
    check("stall_tready_low", stall_ok, 1'b1);
    check("stall_out_stable", stable_ok, 1'b1);
    check("stall_no_out", q_re.size(), 0);
    m_im.tready = 1'b1;
    wait_acc("stall_b4");
    wait_out(4, "stall_out");
    repeat (5) tick();
    check("stall_count", q_re.size(), 4);
    for (int k = 1; k <= 4; k++) begin
      s16 = 16'(64 * k);
      check($sformatf("stall_re%0d", k), q_re.pop_front(), {8{s16}});
    end
    clear_q();

    // Per-lane ordering: lane i = 128*i with weight 64 -> 64*i
    for (int i = 0; i < 8; i++) begin
      lane_in[i*16 +: 16]  = 16'(128 * i);
      lane_exp[i*16 +: 16] = 16'(64 * i);
    end
    s_re.tdata = lane_in; s_im.tdata = '0;
    s_re.tlast = 1'b1; s_im.tlast = 1'b1;
    s_re.tvalid = 1'b1; s_im.tvalid = 1'b1;
    wait_acc("lane_acc");
    wait_out(1, "lane_out");
    check("lane_re", q_re.pop_front(), lane_exp);
    clear_q();

    // Only real valid: nothing accepted (its tlast=0 would otherwise open a packet)
    s_re.tdata = {8{16'd1000}}; s_re.tlast = 1'b0; s_re.tvalid = 1'b1; s_im.tvalid = 1'b0;
    repeat (8) tick();
    s_re.tvalid = 1'b0;
    check("mismatch_no_out", q_re.size(), 0);
    load_w(8'sd127, 8'sd0);
    drive(16'd1000, 16'd0, 1'b1);
    wait_acc("mismatch_after");
    wait_out(1, "mismatch_after_out");
    check("mismatch_state_idle", q_re.pop_front(), {8{16'd992}});
    clear_q();

    // Reset with two beats in flight: flushed, weights back to 127+j0
    load_w(8'sd64, 8'sd0);
    drive(16'd1000, 16'd0, 1'b1);
    wait_acc("flush_b1");
    drive(16'd1000, 16'd0, 1'b1);
    wait_acc("flush_b2");
    resetn = 1'b0;
    tick();
    @(negedge clock);
    check("flush_in_reset", {m_re.tvalid, m_im.tvalid, s_re.tready, s_im.tready}, 4'b0);
    tick();
    resetn = 1'b1;
    repeat (6) tick();
    check("flush_no_out", q_re.size(), 0);
    check("flush_sat", sat_count, 16'd0);
    drive(16'd1000, 16'd0, 1'b1);
    wait_acc("flush_after");
    wait_out(1, "flush_after_out");
    check("flush_weight_reset", q_re.pop_front(), {8{16'd992}});
    clear_q();

    // 16 clips per beat: 4095 beats -> 65520, two more -> sticks at FFFF
    load_w(-8'sd128, -8'sd128);
    for (int k = 0; k < 4095; k++) begin
      drive(16'h8000, 16'd0, 1'b1);
      wait_acc("satc_acc");
    end
    wait_out(4095, "satc_out");
    tick();
    check("satc_re", q_re[0], {8{16'h7FFF}});
    check("satc_im", q_im[0], {8{16'h7FFF}});
    check("satc_65520", sat_count, 16'hFFF0);
    clear_q();
    for (int k = 0; k < 2; k++) begin
      drive(16'h8000, 16'd0, 1'b1);
      wait_acc("satc_acc2");
    end
    wait_out(2, "satc_out2");
    tick();
    check("satc_stick", sat_count, 16'hFFFF);

    check("valid_pair", pair_err, 0);
    check("tkeep_rule", keep_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
